// File: rtl/jtframe_mc2_joy_pkg.sv
// Shared types and bit/pin indices for the MC2 DB9 Mega Drive pad reader.
package jtframe_mc2_joy_pkg;

   typedef enum logic [3:0] {
      IDLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7
   } joy_state_e;

   // joystick word bit positions (active high)
   localparam int unsigned JB_RIGHT   = 0;
   localparam int unsigned JB_LEFT    = 1;
   localparam int unsigned JB_DOWN    = 2;
   localparam int unsigned JB_UP      = 3;
   localparam int unsigned JB_B       = 4;
   localparam int unsigned JB_C       = 5;
   localparam int unsigned JB_A       = 6;
   localparam int unsigned JB_START   = 7;
   localparam int unsigned JB_Z       = 8;
   localparam int unsigned JB_Y       = 9;
   localparam int unsigned JB_X       = 10;
   localparam int unsigned JB_MODE    = 11;
   localparam int unsigned JB_PRESENT = 14;
   localparam int unsigned JB_SIX     = 15;

   // DB9 pin positions within joy_in (active low)
   localparam int unsigned P_UP    = 0;
   localparam int unsigned P_DOWN  = 1;
   localparam int unsigned P_LEFT  = 2;
   localparam int unsigned P_RIGHT = 3;
   localparam int unsigned P_TL    = 4;
   localparam int unsigned P_TR    = 5;

   localparam int unsigned PIN_W = 6;
   localparam int unsigned JOY_W = 16;

endpackage

// File: rtl/jtframe_mc2_sync.sv
// Two-flop synchroniser with asynchronous reset to a preset value.
module jtframe_mc2_sync #(
   parameter int unsigned W      = 1,
   parameter logic [W-1:0] PRESET = '0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= PRESET;
         sync_q <= PRESET;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/jtframe_mc2_joydb9.sv
// Polls a Mega Drive 3/6-button pad on the MC2 DB9 port and publishes one
// active-high joystick word per poll, updated atomically.
module jtframe_mc2_joydb9
   import jtframe_mc2_joy_pkg::*;
#(
   parameter int unsigned SEL_CYCLES  = 480,
   parameter int unsigned IDLE_CYCLES = 96000
)(
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [PIN_W-1:0] joy_in,
   output logic             joy_sel,
   output logic [JOY_W-1:0] joystick,
   output logic             joy_valid
);

   localparam int unsigned MAX_CYC = (SEL_CYCLES > IDLE_CYCLES) ? SEL_CYCLES : IDLE_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

   logic [PIN_W-1:0] s;
   joy_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [JOY_W-1:0] shadow_q, shadow_d;
   logic [JOY_W-1:0] joystick_q, joystick_d;
   logic             joy_sel_q, joy_sel_d;
   logic             joy_valid_q, joy_valid_d;
   logic             phase_end;

   jtframe_mc2_sync #(.W(PIN_W), .PRESET(6'h3F)) u_sync (
      .clk (clk_sys),
      .rst (rst),
      .d   (joy_in),
      .q   (s)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         joystick_q  <= '0;
         joy_sel_q   <= 1'b1;
         joy_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         joystick_q  <= joystick_d;
         joy_sel_q   <= joy_sel_d;
         joy_valid_q <= joy_valid_d;
      end
   end

   // Sampling happens only on the last cycle of a phase, when pins have settled.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      shadow_d    = shadow_q;
      joystick_d  = joystick_q;
      joy_valid_d = 1'b0;
      phase_end   = (state_q == IDLE) ? (cnt_q == IDLE_LAST) : (cnt_q == SEL_LAST);

      if (phase_end) begin
         cnt_d = '0;
         case (state_q)
            PH0: begin
               shadow_d[JB_UP]    = ~s[P_UP];
               shadow_d[JB_DOWN]  = ~s[P_DOWN];
               shadow_d[JB_LEFT]  = ~s[P_LEFT];
               shadow_d[JB_RIGHT] = ~s[P_RIGHT];
               shadow_d[JB_B]     = ~s[P_TL];
               shadow_d[JB_C]     = ~s[P_TR];
            end
            PH1: begin
               shadow_d[JB_A]       = ~s[P_TL];
               shadow_d[JB_START]   = ~s[P_TR];
               shadow_d[JB_PRESENT] = ~s[P_LEFT] & ~s[P_RIGHT];
            end
            PH5: shadow_d[JB_SIX] = (s[P_RIGHT:P_UP] == 4'b0000);
            PH6: begin
               if (shadow_q[JB_SIX]) begin
                  shadow_d[JB_Z]    = ~s[P_UP];
                  shadow_d[JB_Y]    = ~s[P_DOWN];
                  shadow_d[JB_X]    = ~s[P_LEFT];
                  shadow_d[JB_MODE] = ~s[P_RIGHT];
               end else begin
                  shadow_d[JB_MODE:JB_Z] = 4'b0000;
               end
            end
            PH7: begin
               joy_valid_d = 1'b1;
               if (!shadow_q[JB_PRESENT]) begin
                  joystick_d = '0;
               end else begin
                  joystick_d        = shadow_q;
                  joystick_d[13:12] = 2'b00;
                  if (!shadow_q[JB_SIX]) begin
                     joystick_d[JB_MODE:JB_Z] = 4'b0000;
                     joystick_d[JB_SIX]       = 1'b0;
                  end
               end
            end
            default: ;
         endcase

         if (state_q == PH7) state_d = IDLE;
         else                state_d = joy_state_e'(4'(state_q) + 4'd1);
      end

      joy_sel_d = !(state_d inside {PH1, PH3, PH5, PH7});
   end

   assign joy_sel   = joy_sel_q;
   assign joystick  = joystick_q;
   assign joy_valid = joy_valid_q;

endmodule

// File: tb/tb_jtframe_mc2_joydb9.sv
// Directed bench for jtframe_mc2_joydb9 with a behavioural Mega Drive pad.
module tb_jtframe_mc2_joydb9;

   localparam int unsigned SEL    = 4;
   localparam int unsigned IDLE   = 16;
   localparam int unsigned PERIOD = 8 * SEL + IDLE;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  joy_in;
   logic        joy_sel;
   logic [15:0] joystick;
   logic        joy_valid;

   always #5 clk = ~clk;

   jtframe_mc2_joydb9 #(.SEL_CYCLES(SEL), .IDLE_CYCLES(IDLE)) dut (
      .clk_sys   (clk),
      .rst       (rst),
      .joy_in    (joy_in),
      .joy_sel   (joy_sel),
      .joystick  (joystick),
      .joy_valid (joy_valid)
   );

   // pad model: btn uses joystick bit order [0]R..[7]Start [8]Z [9]Y [10]X [11]Mode
   logic        pad_en, pad_six;
   logic [11:0] btn;
   int          lows_done = 0;
   int          hi_cnt    = 0;
   logic        prev_sel  = 1'b1;

   always @(negedge clk) begin
      prev_sel <= joy_sel;
      hi_cnt   <= joy_sel ? hi_cnt + 1 : 0;
      if (hi_cnt > 8)                lows_done <= 0;
      else if (joy_sel && !prev_sel) lows_done <= lows_done + 1;
   end

   always_comb begin
      joy_in = 6'h3F;
      if (pad_en) begin
         if (!joy_sel) begin
            if (pad_six && lows_done == 2)      joy_in = {~btn[7], ~btn[6], 4'b0000};
            else if (pad_six && lows_done == 3) joy_in = {~btn[7], ~btn[6], 4'b1111};
            else joy_in = {~btn[7], ~btn[6], 2'b00, ~btn[2], ~btn[3]};
         end else if (pad_six && lows_done == 3) begin
            joy_in = {~btn[5], ~btn[4], ~btn[11], ~btn[10], ~btn[9], ~btn[8]};
         end else begin
            joy_in = {~btn[5], ~btn[4], ~btn[0], ~btn[1], ~btn[2], ~btn[3]};
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Waits for the next joy_valid, measuring cycles and SELECT low pulses.
   task automatic wait_valid(output int cyc, output int lows, output int badlen);
      int run;
      cyc = 0; lows = 0; badlen = 0; run = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!joy_sel) run++;
         else if (run != 0) begin
            lows++;
            if (run != SEL) badlen++;
            run = 0;
         end
      end while (!joy_valid && cyc < 4 * PERIOD);
   endtask

   typedef struct {
      logic        en;
      logic        six;
      logic [11:0] btn;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cyc, lows, bad, changes;
      logic [15:0] prev;

      vecs[0] = '{1'b1, 1'b0, 12'h041, 16'h4041};  // 3-btn A+Right
      vecs[1] = '{1'b1, 1'b1, 12'h980, 16'hC980};  // 6-btn Z+Mode+Start
      vecs[2] = '{1'b0, 1'b0, 12'h000, 16'h0000};  // no pad
      vecs[3] = '{1'b1, 1'b0, 12'h0B8, 16'h40B8};  // 3-btn U+B+C+Start
      vecs[4] = '{1'b1, 1'b1, 12'hFFF, 16'hCFFF};  // 6-btn everything
      vecs[5] = '{1'b1, 1'b1, 12'h606, 16'hC606};  // 6-btn X+Y+D+L
      vecs[6] = '{1'b1, 1'b0, 12'h100, 16'h4000};  // 3-btn cannot report Z
      vecs[7] = '{1'b1, 1'b1, 12'h000, 16'hC000};  // 6-btn idle

      rst = 1'b1; pad_en = 1'b0; pad_six = 1'b0; btn = 12'h000;
      repeat (5) @(negedge clk);
      check("rst_sel", 32'(joy_sel), 32'd1);
      check("rst_joy", 32'(joystick), 32'h0);
      check("rst_valid", 32'(joy_valid), 32'd0);
      rst = 1'b0;

      wait_valid(cyc, lows, bad);
      check("first_valid_latency", 32'(cyc), 32'(PERIOD));
      check("first_joy", 32'(joystick), 32'h0);

      foreach (vecs[i]) begin
         pad_en = vecs[i].en; pad_six = vecs[i].six; btn = vecs[i].btn;
         wait_valid(cyc, lows, bad);
         wait_valid(cyc, lows, bad);
         check($sformatf("vec%0d_period", i), 32'(cyc), 32'(PERIOD));
         check($sformatf("vec%0d_sel_lows", i), 32'(lows), 32'd4);
         check($sformatf("vec%0d_sel_len", i), 32'(bad), 32'd0);
         check($sformatf("vec%0d_joy", i), 32'(joystick), 32'(vecs[i].exp));
      end

      // reset in PH3 with a 6-button pad, then a different button set
      pad_en = 1'b1; pad_six = 1'b1; btn = 12'hD00;
      wait_valid(cyc, lows, bad);
      wait_valid(cyc, lows, bad);
      check("pre_rst_joy", 32'(joystick), 32'hCD00);
      repeat (29) @(negedge clk);
      check("ph3_sel_low", 32'(joy_sel), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_sel", 32'(joy_sel), 32'd1);
      check("midrst_joy", 32'(joystick), 32'h0);
      check("midrst_valid", 32'(joy_valid), 32'd0);
      repeat (3) @(negedge clk);
      btn = 12'h200;
      rst = 1'b0;
      wait_valid(cyc, lows, bad);
      check("post_rst_latency", 32'(cyc), 32'(PERIOD));
      check("post_rst_joy", 32'(joystick), 32'hC200);

      // buttons churn every cycle; the output may only move on joy_valid
      changes = 0;
      prev = joystick;
      for (int i = 0; i < 3 * int'(PERIOD); i++) begin
         @(negedge clk);
         if (joystick !== prev && !joy_valid) changes++;
         prev = joystick;
         btn = 12'($urandom);
      end
      check("hold_between_valid", 32'(changes), 32'd0);

      btn = 12'h0A5;
      wait_valid(cyc, lows, bad);
      wait_valid(cyc, lows, bad);
      check("after_churn_lows", 32'(lows), 32'd4);
      check("after_churn_joy", 32'(joystick), 32'hC0A5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
